// File: rtl/riscv_muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// funct3 op encodings, FSM state encoding and operand-class helpers.
package riscv_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Divide/remainder ops all have funct3[2] set.
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // REM and REMU return the remainder rather than the quotient.
  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // srcA is interpreted as two's complement. MUL is treated as signed:
  // the low half of the product is identical either way.
  function automatic logic is_signed_a(input logic [2:0] op);
    logic res;
    case (op)
      OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: res = 1'b1;
      default:                                    res = 1'b0;
    endcase
    return res;
  endfunction

  // srcB is interpreted as two's complement.
  function automatic logic is_signed_b(input logic [2:0] op);
    logic res;
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: res = 1'b1;
      default:                         res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes
// on acceptance, a radix-2 shift-add multiply or restoring divide runs for
// XLEN iterations on one shared XLEN+1 adder and a 2*XLEN shift register,
// and the sign is restored in FIX. Divide-by-zero and signed overflow
// bypass the iteration and finish straight from IDLE.
module riscv_muldiv
  import riscv_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_r;
  logic [2:0]          op_r;
  logic                neg_q_r;    // product / quotient must be negated
  logic                neg_r_r;    // remainder must be negated
  logic [XLEN-1:0]     mcand_r;    // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   prod_r;     // {hi, lo}: product, or {remainder, quotient}
  logic [CNT_W-1:0]    cnt_r;
  logic                busy_r;
  logic                done_r;
  logic [XLEN-1:0]     result_r;

  logic                sa_s, sb_s;
  logic [XLEN-1:0]     mag_a_s, mag_b_s;
  logic                fast_s;
  logic [XLEN-1:0]     fast_val_s;
  logic [XLEN:0]       add_a_s, add_b_s;
  logic                add_cin_s;
  logic [XLEN+1:0]     add_sum_s;
  logic [2*XLEN-1:0]   iter_s;
  logic [2*XLEN-1:0]   prod_neg_s;
  logic [XLEN-1:0]     quo_s, rem_s;
  logic [XLEN-1:0]     fix_val_s;

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

  // Operand magnitudes and the one-cycle boundary results for the divides.
  always_comb begin
    sa_s       = is_signed_a(op) & srcA[XLEN-1];
    sb_s       = is_signed_b(op) & srcB[XLEN-1];
    mag_a_s    = sa_s ? (-srcA) : srcA;
    mag_b_s    = sb_s ? (-srcB) : srcB;
    fast_s     = 1'b0;
    fast_val_s = ZERO;
    if (is_div(op)) begin
      if (srcB == ZERO) begin
        fast_s     = 1'b1;
        fast_val_s = is_rem(op) ? srcA : ALL_ONES;
      end else if (is_signed_b(op) && (srcA == MIN_NEG) && (srcB == ALL_ONES)) begin
        fast_s     = 1'b1;
        fast_val_s = is_rem(op) ? ZERO : MIN_NEG;
      end else begin
        fast_s     = 1'b0;
        fast_val_s = ZERO;
      end
    end else begin
      fast_s     = 1'b0;
      fast_val_s = ZERO;
    end
  end

  // Shared adder: accumulate for multiply, trial-subtract for divide.
  always_comb begin
    if (is_div(op_r)) begin
      add_a_s   = prod_r[2*XLEN-1:XLEN-1];
      add_b_s   = ~{1'b0, mcand_r};
      add_cin_s = 1'b1;
    end else begin
      add_a_s   = {1'b0, prod_r[2*XLEN-1:XLEN]};
      add_b_s   = {1'b0, mcand_r};
      add_cin_s = 1'b0;
    end
    add_sum_s = {1'b0, add_a_s} + {1'b0, add_b_s} + {{(XLEN+1){1'b0}}, add_cin_s};
  end

  // Next shift-register value for one iteration.
  always_comb begin
    if (is_div(op_r)) begin
      // Carry out set means the shifted partial remainder >= divisor.
      if (add_sum_s[XLEN+1]) begin
        iter_s = {add_sum_s[XLEN-1:0], prod_r[XLEN-2:0], 1'b1};
      end else begin
        iter_s = {prod_r[2*XLEN-2:0], 1'b0};
      end
    end else begin
      if (prod_r[0]) begin
        iter_s = {add_sum_s[XLEN:0], prod_r[XLEN-1:1]};
      end else begin
        iter_s = {1'b0, prod_r[2*XLEN-1:1]};
      end
    end
  end

  // Sign correction and half/quotient/remainder selection for FIX.
  always_comb begin
    prod_neg_s = -prod_r;
    quo_s      = prod_r[XLEN-1:0];
    rem_s      = prod_r[2*XLEN-1:XLEN];
    case (op_r)
      OP_MUL:                       fix_val_s = neg_q_r ? prod_neg_s[XLEN-1:0] : prod_r[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val_s = neg_q_r ? prod_neg_s[2*XLEN-1:XLEN] : prod_r[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_val_s = neg_q_r ? (-quo_s) : quo_s;
      OP_REM, OP_REMU:              fix_val_s = neg_r_r ? (-rem_s) : rem_s;
      default:                      fix_val_s = ZERO;
    endcase
  end

  // Control FSM with registered busy/done/result and the iteration state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      op_r     <= OP_MUL;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      mcand_r  <= ZERO;
      prod_r   <= {(2*XLEN){1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            if (fast_s) begin
              result_r <= fast_val_s;
              done_r   <= 1'b1;
              state_r  <= ST_DONE;
            end else begin
              op_r    <= op;
              neg_q_r <= sa_s ^ sb_s;
              neg_r_r <= sa_s;
              cnt_r   <= {CNT_W{1'b0}};
              busy_r  <= 1'b1;
              state_r <= ST_CALC;
              if (is_div(op)) begin
                mcand_r <= mag_b_s;
                prod_r  <= {ZERO, mag_a_s};
              end else begin
                mcand_r <= mag_a_s;
                prod_r  <= {ZERO, mag_b_s};
              end
            end
          end
        end
        ST_CALC: begin
          prod_r <= iter_s;
          cnt_r  <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) begin
            state_r <= ST_FIX;
          end
        end
        ST_FIX: begin
          result_r <= fix_val_s;
          busy_r   <= 1'b0;
          done_r   <= 1'b1;
          state_r  <= ST_DONE;
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
